// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// One-word lines, byte-granular stores, req/ack backing memory and a dirty-line flush walk.
module dmem_cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  input  logic [DATA_W/8-1:0]           cpu_be,
  input  logic                          cpu_wen,
  input  logic                          cpu_ren,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_ready,
  input  logic                          flush,
  output logic                          flush_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0] mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WRITEBACK  = 3'd1;
  localparam logic [2:0] S_REFILL     = 3'd2;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
  localparam logic [2:0] S_FLUSH_WB   = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [DATA_W-1:0]        data_q [LINES];
  logic [INDEX_W-1:0]       scan_q, scan_d;
  logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-OFF_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
  logic                     flush_done_q, flush_done_d;

  logic [INDEX_W-1:0]       cpu_index;
  logic [TAG_W-1:0]         cpu_tag;
  logic [ADDR_W-OFF_W-1:0]  cpu_word;
  logic                     access, hit, ack;
  logic                     line_we;
  logic [DATA_W-1:0]        line_data;
  logic                     unused_off;

  assign cpu_index  = cpu_addr[OFF_W+INDEX_W-1:OFF_W];
  assign cpu_tag    = cpu_addr[ADDR_W-1:OFF_W+INDEX_W];
  assign cpu_word   = cpu_addr[ADDR_W-1:OFF_W];
  assign unused_off = ^cpu_addr[OFF_W-1:0];

  assign access = cpu_ren | cpu_wen;
  assign hit    = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
  assign ack    = mem_ack & mem_req_q;

  assign cpu_ready  = (state_q == S_IDLE) && (!access || hit);
  assign cpu_rdata  = data_q[cpu_index];
  assign flush_done = flush_done_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                              input logic [DATA_W-1:0] wr,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = base;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) res[i*8 +: 8] = wr[i*8 +: 8];
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    scan_d       = scan_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    flush_done_d = 1'b0;
    line_we      = 1'b0;
    line_data    = merge(data_q[cpu_index], cpu_wdata, cpu_be);

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (hit) begin
            if (cpu_wen) begin
              line_we            = 1'b1;
              dirty_d[cpu_index] = 1'b1;
            end
          end else if (valid_q[cpu_index] && dirty_q[cpu_index]) begin
            state_d     = S_WRITEBACK;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[cpu_index], cpu_index};
            mem_wdata_d = data_q[cpu_index];
          end else begin
            state_d    = S_REFILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = cpu_word;
          end
        end else if (flush) begin
          state_d = S_FLUSH_SCAN;
          scan_d  = '0;
        end
      end
      S_WRITEBACK: begin
        if (ack) begin
          state_d    = S_REFILL;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu_word;
        end
      end
      S_REFILL: begin
        // The line only becomes valid here, so an aborted refill never leaves a half-written line.
        if (ack) begin
          line_we            = 1'b1;
          line_data          = merge(mem_rdata, cpu_wdata, cpu_wen ? cpu_be : '0);
          valid_d[cpu_index] = 1'b1;
          dirty_d[cpu_index] = cpu_wen;
          mem_req_d          = 1'b0;
          mem_we_d           = 1'b0;
          state_d            = S_IDLE;
        end
      end
      S_FLUSH_SCAN: begin
        if (valid_q[scan_q] && dirty_q[scan_q]) begin
          state_d     = S_FLUSH_WB;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {tag_q[scan_q], scan_q};
          mem_wdata_d = data_q[scan_q];
        end else if (scan_q == '1) begin
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_FLUSH_WB: begin
        if (ack) begin
          dirty_d[scan_q] = 1'b0;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          if (scan_q == '1) begin
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            scan_d  = scan_q + 1'b1;
            state_d = S_FLUSH_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      scan_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      scan_q       <= scan_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[cpu_index]  <= cpu_tag;
      data_q[cpu_index] <= line_data;
    end
  end
endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Directed bench for dmem_cache_ctrl: hits, clean/dirty misses, store-miss merge,
// zero-wait memory, flush walk and reset during a refill.
module tb_dmem_cache_ctrl;
  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_wen;
  logic        cpu_ren;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic        flush_done;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;
  int n;
  int writes;

  dmem_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(6)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush), .flush_done(flush_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0; cpu_wen = 1'b0; cpu_ren = 1'b0;
    flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_cpu_ready", cpu_ready, 1);
    reset = 1'b0;

    // Clean load miss at 0x100, ack in the third cycle of the request
    cpu_addr = 32'h100; cpu_ren = 1'b1; settle();
    chk("t1_miss_ready", cpu_ready, 0);
    step();
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 0);
    chk("t1_addr", mem_addr, 30'h40);
    chk("t1_stall", cpu_ready, 0);
    step();
    chk("t1_req_hold", mem_req, 1);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
    chk("t1_ack_cycle_ready", cpu_ready, 0);
    step();
    mem_ack = 1'b0; settle();
    chk("t1_done_ready", cpu_ready, 1);
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_req_drop", mem_req, 0);
    step();
    chk("t1_rehit_ready", cpu_ready, 1);
    chk("t1_rehit_rdata", cpu_rdata, 32'hDEADBEEF);

    // Byte store hit, then dirty eviction by 0x200
    cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_wdata = 32'h000000AA; cpu_be = 4'b0001; settle();
    chk("t2_store_hit_ready", cpu_ready, 1);
    chk("t2_store_prestore_rdata", cpu_rdata, 32'hDEADBEEF);
    step();
    cpu_wen = 1'b0; cpu_ren = 1'b1; settle();
    chk("t2_load_merged", cpu_rdata, 32'hDEADBEAA);
    chk("t2_load_ready", cpu_ready, 1);
    step();
    cpu_addr = 32'h200; settle();
    chk("t2_miss_ready", cpu_ready, 0);
    step();
    chk("t2_wb_req", mem_req, 1);
    chk("t2_wb_we", mem_we, 1);
    chk("t2_wb_addr", mem_addr, 30'h40);
    chk("t2_wb_wdata", mem_wdata, 32'hDEADBEAA);
    mem_ack = 1'b1; mem_rdata = 32'h55667788;
    step();
    chk("t2_rf_req", mem_req, 1);
    chk("t2_rf_we", mem_we, 0);
    chk("t2_rf_addr", mem_addr, 30'h80);
    chk("t2_rf_ready", cpu_ready, 0);
    step();
    mem_ack = 1'b0; settle();
    chk("t2_done_ready", cpu_ready, 1);
    chk("t2_rdata", cpu_rdata, 32'h55667788);

    // Store miss to 0x304 merges upper bytes into the refilled word
    step();
    cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr = 32'h304; cpu_be = 4'b1100; cpu_wdata = 32'h12340000;
    settle();
    chk("t3_miss_ready", cpu_ready, 0);
    step();
    chk("t3_rf_req", mem_req, 1);
    chk("t3_rf_we", mem_we, 0);
    chk("t3_rf_addr", mem_addr, 30'hC1);
    mem_ack = 1'b1; mem_rdata = 32'h0000FFFF;
    step();
    mem_ack = 1'b0; settle();
    chk("t3_hit_ready", cpu_ready, 1);
    step();
    cpu_wen = 1'b0; cpu_ren = 1'b1; settle();
    chk("t3_rdata", cpu_rdata, 32'h1234FFFF);
    step();
    cpu_addr = 32'h404; settle();
    chk("t3_evict_ready", cpu_ready, 0);
    step();
    chk("t3_evict_we", mem_we, 1);
    chk("t3_evict_addr", mem_addr, 30'hC1);
    chk("t3_evict_wdata", mem_wdata, 32'h1234FFFF);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    chk("t3_rf2_addr", mem_addr, 30'h101);
    step();
    mem_ack = 1'b0; settle();
    chk("t3_rf2_ready", cpu_ready, 1);

    // Zero-wait memory: ack tied high, a clean miss stalls two cycles
    step();
    cpu_addr = 32'h500; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; settle();
    n = 0;
    while (!cpu_ready && n < 20) begin step(); n++; end
    chk("t4_stall_cycles", n, 2);
    chk("t4_rdata", cpu_rdata, 32'hCAFEF00D);

    // Dirty lines at index 3 and 63 via store misses with zero-wait memory
    step();
    cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr = 32'h00C; cpu_wdata = 32'h11111111; cpu_be = 4'hF;
    mem_rdata = 32'h0BADF00D; settle();
    n = 0;
    while (!cpu_ready && n < 20) begin step(); n++; end
    chk("t5_store3_stall", n, 2);
    step();
    cpu_addr = 32'h7FC; cpu_wdata = 32'h22222222; settle();
    n = 0;
    while (!cpu_ready && n < 20) begin step(); n++; end
    chk("t5_store63_stall", n, 2);
    step();
    mem_ack = 1'b0; cpu_wen = 1'b0; flush = 1'b1; settle();
    chk("t5_idle_ready", cpu_ready, 1);
    step();
    flush = 1'b0; settle();
    chk("t5_scan_ready", cpu_ready, 0);
    n = 0;
    while (!mem_req && n < 200) begin step(); n++; end
    chk("t5_wb3_delay", n, 4);
    chk("t5_wb3_we", mem_we, 1);
    chk("t5_wb3_addr", mem_addr, 30'h003);
    chk("t5_wb3_wdata", mem_wdata, 32'h11111111);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; settle();
    chk("t5_wb3_req_drop", mem_req, 0);
    chk("t5_wb3_no_done", flush_done, 0);
    n = 0;
    while (!mem_req && n < 200) begin step(); n++; end
    chk("t5_wb63_delay", n, 60);
    chk("t5_wb63_addr", mem_addr, 30'h1FF);
    chk("t5_wb63_wdata", mem_wdata, 32'h22222222);
    step();
    chk("t5_wb63_hold", mem_req, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; settle();
    chk("t5_flush_done", flush_done, 1);
    chk("t5_done_req", mem_req, 0);
    chk("t5_done_ready", cpu_ready, 1);
    step();
    chk("t5_done_pulse", flush_done, 0);

    // Second flush finds nothing dirty; lines stay valid
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0; writes = 0;
    while (!flush_done && n < 200) begin
      step(); n++;
      if (mem_req) writes++;
    end
    chk("t5_reflush_cycles", n, 64);
    chk("t5_reflush_writes", writes, 0);
    cpu_ren = 1'b1; cpu_addr = 32'h00C; settle();
    chk("t5_keep3_ready", cpu_ready, 1);
    chk("t5_keep3_rdata", cpu_rdata, 32'h11111111);
    cpu_addr = 32'h7FC; settle();
    chk("t5_keep63_rdata", cpu_rdata, 32'h22222222);

    // Reset during refill drops mem_req at once and invalidates the cache
    step();
    cpu_addr = 32'h600; settle();
    chk("t6_miss_ready", cpu_ready, 0);
    step();
    chk("t6_rf_req", mem_req, 1);
    chk("t6_rf_addr", mem_addr, 30'h180);
    reset = 1'b1; settle();
    chk("t6_async_req_drop", mem_req, 0);
    mem_ack = 1'b1; settle();
    reset = 1'b0; mem_ack = 1'b0; settle();
    chk("t6_remiss_ready", cpu_ready, 0);
    step();
    chk("t6_rerf_req", mem_req, 1);
    chk("t6_rerf_addr", mem_addr, 30'h180);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    step();
    mem_ack = 1'b0; settle();
    chk("t6_done_ready", cpu_ready, 1);
    chk("t6_rdata", cpu_rdata, 32'h77777777);
    cpu_addr = 32'h00C; settle();
    chk("t6_invalidated", cpu_ready, 0);
    cpu_ren = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
